// File: rtl/alu_adder_unit_if.sv
`default_nettype none
// =============================================================================
// Module   : alu_adder_unit_if
// Brief    : Operand/PC request and registered result bundle for alu_adder_unit.
// Revision : 1.0 - initial release
// =============================================================================
interface alu_adder_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] sign_imm;

  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output in_valid, alu_op, src_a, src_b, pc, sign_imm,
    input  out_valid, alu_out, zero, overflow, pc_plus4, branch_target
  );

  modport slave (
    input  in_valid, alu_op, src_a, src_b, pc, sign_imm,
    output out_valid, alu_out, zero, overflow, pc_plus4, branch_target
  );
endinterface
`default_nettype wire

// File: rtl/alu_adder_unit.sv
`default_nettype none
// =============================================================================
// Module   : alu_adder_unit
// Brief    : Single-cycle registered ALU with PC+4 and branch-target adders.
// Revision : 1.0 - initial release
// =============================================================================
module alu_adder_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  alu_adder_unit_if.slave    bus
);

  localparam int         c_shw     = $clog2(WIDTH);
  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_nor  = 4'b0100;
  localparam logic [3:0] c_op_sll  = 4'b0101;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_sltu = 4'b1000;
  localparam logic [3:0] c_op_srl  = 4'b1001;
  localparam logic [3:0] c_op_sra  = 4'b1010;
  localparam logic [3:0] c_op_lui  = 4'b1011;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [c_shw-1:0] w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sra;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch_target;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_overflow;
  logic [WIDTH-1:0] r_pc_plus4;
  logic [WIDTH-1:0] r_branch_target;

  assign w_a       = bus.src_a;
  assign w_b       = bus.src_b;
  assign w_shamt   = w_b[c_shw-1:0];
  assign w_sum     = w_a + w_b;
  assign w_diff    = w_a - w_b;
  assign w_sra     = $signed(w_a) >>> w_shamt;
  assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1]  != w_a[WIDTH-1]);
  assign w_sub_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

  // Offset is in words; bits shifted out of the top are intentionally dropped.
  assign w_pc_plus4      = bus.pc + WIDTH'(4);
  assign w_branch_target = w_pc_plus4 + (bus.sign_imm << 2);

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (bus.alu_op)
      c_op_and:  w_result = w_a & w_b;
      c_op_or:   w_result = w_a | w_b;
      c_op_add:  begin w_result = w_sum;  w_ovf = w_add_ovf; end
      c_op_xor:  w_result = w_a ^ w_b;
      c_op_nor:  w_result = ~(w_a | w_b);
      c_op_sll:  w_result = w_a << w_shamt;
      c_op_sub:  begin w_result = w_diff; w_ovf = w_sub_ovf; end
      c_op_slt:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      c_op_sltu: w_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      c_op_srl:  w_result = w_a >> w_shamt;
      c_op_sra:  w_result = w_sra;
      c_op_lui:  w_result = w_b << 16;
      default:   begin w_result = '0; w_ovf = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_alu_out       <= '0;
      r_zero          <= 1'b0;
      r_overflow      <= 1'b0;
      r_pc_plus4      <= '0;
      r_branch_target <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_alu_out       <= w_result;
        r_zero          <= (w_result == '0);
        r_overflow      <= w_ovf;
        r_pc_plus4      <= w_pc_plus4;
        r_branch_target <= w_branch_target;
      end
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.alu_out       = r_alu_out;
  assign bus.zero          = r_zero;
  assign bus.overflow      = r_overflow;
  assign bus.pc_plus4      = r_pc_plus4;
  assign bus.branch_target = r_branch_target;

endmodule
`default_nettype wire

// File: tb/tb_alu_adder_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_adder_unit
// Brief    : Directed self-checking bench for alu_adder_unit.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alu_adder_unit;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  logic [31:0] exp_alu;
  logic        exp_z;
  logic        exp_ov;
  logic [31:0] exp_p4;
  logic [31:0] exp_bt;

  alu_adder_unit_if #(.WIDTH(32)) bus ();

  alu_adder_unit #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, ".alu"}, bus.alu_out, exp_alu);
    check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp_z});
    check({tag, ".ovf"}, {31'b0, bus.overflow}, {31'b0, exp_ov});
    check({tag, ".pc4"}, bus.pc_plus4, exp_p4);
    check({tag, ".bt"}, bus.branch_target, exp_bt);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] imm);
    @(negedge clk);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.pc       = p;
    bus.sign_imm = imm;
  endtask

  // Apply one valid vector; outputs must not move before the edge, then match after it.
  task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] imm,
                         input logic [31:0] e_alu, input logic e_z, input logic e_ov,
                         input logic [31:0] e_p4, input logic [31:0] e_bt);
    drive(1'b1, op, a, b, p, imm);
    #1 check({tag, ".pre"}, bus.alu_out, exp_alu);
    @(posedge clk);
    #1;
    exp_alu = e_alu; exp_z = e_z; exp_ov = e_ov; exp_p4 = e_p4; exp_bt = e_bt;
    check({tag, ".vld"}, {31'b0, bus.out_valid}, 32'd1);
    check_held(tag);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_alu = '0; exp_z = 1'b0; exp_ov = 1'b0; exp_p4 = '0; exp_bt = '0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'b0010;
    bus.src_a    = 32'h1111_1111;
    bus.src_b    = 32'h2222_2222;
    bus.pc       = 32'h0000_1000;
    bus.sign_imm = 32'h0000_0001;

    #1;
    check("rst.vld", {31'b0, bus.out_valid}, 32'd0);
    check_held("rst");
    @(posedge clk);
    #1 check("rst_hold.alu", bus.alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //            tag      op       a             b             pc            imm           alu           z     ov    pc4           bt
    run_vec("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h80000000, 1'b0, 1'b1, 32'h4,        32'h4);
    run_vec("sub_zero", 4'b0110, 32'h5,        32'h5,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h4,        32'h4);
    run_vec("slt",      4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h1,        1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("sltu",     4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h4,        32'h4);
    run_vec("nor",      4'b0100, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("sra",      4'b1010, 32'h80000000, 32'h00000024, 32'h0,        32'h0,        32'hF8000000, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("srl",      4'b1001, 32'h80000000, 32'h00000024, 32'h0,        32'h0,        32'h08000000, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("lui",      4'b1011, 32'hDEADBEEF, 32'h00001234, 32'h0,        32'h0,        32'h12340000, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        32'h00F000F0, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("or",       4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        32'hFFF0FFF0, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("xor",      4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        32'hFF00FF00, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("sll",      4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h80000000, 1'b0, 1'b0, 32'h4,        32'h4);
    run_vec("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        32'h7FFFFFFF, 1'b0, 1'b1, 32'h4,        32'h4);
    run_vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h4,        32'h4);
    run_vec("undef",    4'b1101, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h4,        32'h4);
    run_vec("br_back",  4'b0010, 32'h00000001, 32'h00000002, 32'h00400000, 32'hFFFFFFFF, 32'h3,        1'b0, 1'b0, 32'h00400004, 32'h00400000);
    run_vec("pc_wrap",  4'b0010, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 32'h00000000, 32'h3,        1'b0, 1'b0, 32'h0,        32'h0);
    run_vec("imm_trunc",4'b0010, 32'h00000001, 32'h00000002, 32'h00001000, 32'h40000003, 32'h3,        1'b0, 1'b0, 32'h00001004, 32'h00001010);

    // Valid pattern 1,0,1: the idle cycle must hold the previous results.
    run_vec("p1",       4'b0000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00000100, 32'h00000002, 32'h0F0F0000, 1'b0, 1'b0, 32'h00000104, 32'h0000010C);
    drive(1'b0, 4'b0001, 32'h12345678, 32'h87654321, 32'h00002000, 32'h00000010);
    @(posedge clk);
    #1 check("p0.vld", {31'b0, bus.out_valid}, 32'd0);
    check_held("p0");
    run_vec("p2",       4'b0011, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000200, 32'h00000000, 32'h0,        1'b1, 1'b0, 32'h00000204, 32'h00000204);

    // Mid-stream asynchronous reset drops the pending result.
    drive(1'b1, 4'b0010, 32'd10, 32'd20, 32'h00000300, 32'h00000001);
    #2 rst_n = 1'b0;
    #1;
    exp_alu = '0; exp_z = 1'b0; exp_ov = 1'b0; exp_p4 = '0; exp_bt = '0;
    check("arst.vld", {31'b0, bus.out_valid}, 32'd0);
    check_held("arst");
    @(posedge clk);
    #1 check("arst_edge.alu", bus.alu_out, 32'd0);
    check("arst_edge.vld", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst.vld", {31'b0, bus.out_valid}, 32'd0);
    check_held("post_rst");
    run_vec("post_rst_add", 4'b0010, 32'd10, 32'd20, 32'h00000300, 32'h00000001, 32'd30, 1'b0, 1'b0, 32'h00000304, 32'h00000308);

    drive(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 check("final.vld", {31'b0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
